// File: rtl/icache_fetch_pkg.sv
// Shared definitions for the instruction cache front end.
//   fetch_state_e : refill controller state encoding
//   DEF_*         : default geometry used by icache_fetch
//   OFFSET_BITS / INDEX_BITS / TAG_BITS : address split for the default geometry
//   NOP           : value driven on f_inst whenever no instruction is delivered
package icache_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_FILL   = 2'd2
  } fetch_state_e;

  localparam int DEF_XLEN     = 32;
  localparam int DEF_PC_BITS  = 20;
  localparam int DEF_LINES    = 4;
  localparam int DEF_WORDS    = 4;
  localparam int DEF_CNT_BITS = 32;

  localparam int OFFSET_BITS = $clog2(DEF_WORDS);
  localparam int INDEX_BITS  = $clog2(DEF_LINES);
  localparam int TAG_BITS    = DEF_PC_BITS - OFFSET_BITS - INDEX_BITS;

  localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/icache_refill_fsm.sv
// Refill sequencer for the instruction cache.
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   miss_i          : lookup missed in IDLE (already qualified by f_req and flush)
//   line_addr_i     : line address of the missing fetch
//   mem_ready_i     : memory line-return pulse
//   state_o         : current state
//   mem_req_o       : refill request, held until and including the mem_ready cycle
//   mem_addr_o      : latched miss line address, stable for the whole refill
//   fill_o          : strobe telling the arrays to install mem_rdata this cycle
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | lookups served; a miss latches its line address
// ST_REFILL | request outstanding; waits for mem_ready, installs the line
// ST_FILL   | one bubble so the re-presented f_pc hits on the next cycle
module icache_refill_fsm
  import icache_fetch_pkg::*;
#(
  parameter int LA_W = 18
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            miss_i,
  input  logic [LA_W-1:0] line_addr_i,
  input  logic            mem_ready_i,
  output fetch_state_e    state_o,
  output logic            mem_req_o,
  output logic [LA_W-1:0] mem_addr_o,
  output logic            fill_o
);

  fetch_state_e    state_q;
  logic            mem_req_q;
  logic [LA_W-1:0] miss_addr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      miss_addr_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (miss_i) begin
            state_q     <= ST_REFILL;
            mem_req_q   <= 1'b1;
            miss_addr_q <= line_addr_i;
          end
        end
        ST_REFILL: begin
          if (mem_ready_i) begin
            state_q   <= ST_FILL;
            mem_req_q <= 1'b0;
          end
        end
        ST_FILL: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q   <= ST_IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  // mem_ready outside REFILL never reaches the arrays.
  assign fill_o     = (state_q == ST_REFILL) && mem_ready_i;
  assign state_o    = state_q;
  assign mem_req_o  = mem_req_q;
  assign mem_addr_o = miss_addr_q;

endmodule

// File: rtl/icache_fetch.sv
// Direct-mapped, read-only instruction cache in front of the fetch stage.
//   clk, rst             : clock, asynchronous active-low reset
//   f_req, f_pc, flush   : fetch request, word address, branch redirect
//   f_inst, f_valid      : same-cycle hit data (0 when not valid)
//   stall_f              : fetch must hold f_pc
//   mem_req, mem_addr    : line refill request and line address
//   mem_ready, mem_rdata  : line return pulse and full line (word 0 in LSBs)
//   hit_cnt, miss_cnt    : wrapping performance counters
module icache_fetch
  import icache_fetch_pkg::*;
#(
  parameter int XLEN     = DEF_XLEN,
  parameter int PC_BITS  = DEF_PC_BITS,
  parameter int LINES    = DEF_LINES,
  parameter int WORDS    = DEF_WORDS,
  parameter int CNT_BITS = DEF_CNT_BITS
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              f_req,
  input  logic [PC_BITS-1:0]                f_pc,
  input  logic                              flush,
  output logic [XLEN-1:0]                   f_inst,
  output logic                              f_valid,
  output logic                              stall_f,
  output logic                              mem_req,
  output logic [PC_BITS-$clog2(WORDS)-1:0]  mem_addr,
  input  logic                              mem_ready,
  input  logic [WORDS*XLEN-1:0]             mem_rdata,
  output logic [CNT_BITS-1:0]               hit_cnt,
  output logic [CNT_BITS-1:0]               miss_cnt
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int LA_W  = PC_BITS - OFF_W;
  localparam int TAG_W = LA_W - IDX_W;

  logic [OFF_W-1:0] pc_off;
  logic [IDX_W-1:0] pc_idx;
  logic [TAG_W-1:0] pc_tag;
  logic [LA_W-1:0]  pc_line;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [XLEN-1:0]  data_q [LINES][WORDS];

  logic [CNT_BITS-1:0] hit_cnt_q;
  logic [CNT_BITS-1:0] miss_cnt_q;

  fetch_state_e     state;
  logic             fill;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic             idle;
  logic             hit;
  logic             lookup_hit;
  logic             lookup_miss;

  assign pc_off  = f_pc[OFF_W-1:0];
  assign pc_idx  = f_pc[OFF_W +: IDX_W];
  assign pc_tag  = f_pc[PC_BITS-1 -: TAG_W];
  assign pc_line = f_pc[PC_BITS-1:OFF_W];

  assign idle = (state == ST_IDLE);
  assign hit  = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);

  // A redirect kills both delivery and refill start for the stale pc.
  assign lookup_hit  = idle && f_req && hit  && !flush;
  assign lookup_miss = idle && f_req && !hit && !flush;

  assign f_valid = lookup_hit;
  assign f_inst  = lookup_hit ? data_q[pc_idx][pc_off] : XLEN'(NOP);
  assign stall_f = lookup_miss || !idle;

  icache_refill_fsm #(
    .LA_W (LA_W)
  ) u_refill_fsm (
    .clk_i       (clk),
    .rst_ni      (rst),
    .miss_i      (lookup_miss),
    .line_addr_i (pc_line),
    .mem_ready_i (mem_ready),
    .state_o     (state),
    .mem_req_o   (mem_req),
    .mem_addr_o  (mem_addr),
    .fill_o      (fill)
  );

  assign fill_idx = mem_addr[IDX_W-1:0];
  assign fill_tag = mem_addr[LA_W-1:IDX_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (fill) valid_q[fill_idx] <= 1'b1;
      if (lookup_hit)  hit_cnt_q  <= hit_cnt_q + 1'b1;
      if (lookup_miss) miss_cnt_q <= miss_cnt_q + 1'b1;
    end
  end

  // Tag and data contents are qualified by valid_q, so they carry no reset.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q[fill_idx] <= fill_tag;
      for (int w = 0; w < WORDS; w++) begin
        data_q[fill_idx][w] <= mem_rdata[w*XLEN +: XLEN];
      end
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

endmodule
